ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem.sv | 119 +++++++++++
 tb/tb_ex_mem.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register.
// Carries the EX-stage result, HI/LO update and load/store request into MEM.
// Also carries the multi-cycle (madd/msub) partial result and its cycle count
// back to EX while EX is stalled.
// Widths: RegBus=32, RegAddrBus=5, AluOpBus=8, DoubleRegBus=64.
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [7:0]  mem_aluop,
  output logic [31:0] mem_mem_addr,
  output logic [31:0] mem_reg2,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  // Per-edge action: flush > bubble > advance > hold.
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_ADVANCE = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } act_t;

  act_t act;

  // Decode the stall/flush inputs into one action.
  // A stall of MEM without EX (stall[3]=0, stall[4]=1) falls into advance.
  always_comb begin
    act = ACT_HOLD;
    if (flush)
      act = ACT_FLUSH;
    else if (stall[3] && !stall[4])
      act = ACT_BUBBLE;
    else if (!stall[3])
      act = ACT_ADVANCE;
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_whilo    <= 1'b0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_o       <= '0;
      cnt_o        <= '0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          mem_wd       <= '0;
          mem_wreg     <= 1'b0;
          mem_wdata    <= '0;
          mem_whilo    <= 1'b0;
          mem_hi       <= '0;
          mem_lo       <= '0;
          mem_aluop    <= '0;
          mem_mem_addr <= '0;
          mem_reg2     <= '0;
          hilo_o       <= '0;
          cnt_o        <= '0;
        end
        ACT_BUBBLE: begin
          // Inject a no-write bubble into MEM.
          // Keep the multi-cycle op's partial result flowing back to EX.
          mem_wd       <= '0;
          mem_wreg     <= 1'b0;
          mem_wdata    <= '0;
          mem_whilo    <= 1'b0;
          mem_hi       <= '0;
          mem_lo       <= '0;
          mem_aluop    <= '0;
          mem_mem_addr <= '0;
          mem_reg2     <= '0;
          hilo_o       <= hilo_i;
          cnt_o        <= cnt_i;
        end
        ACT_ADVANCE: begin
          mem_wd       <= ex_wd;
          mem_wreg     <= ex_wreg;
          mem_wdata    <= ex_wdata;
          mem_whilo    <= ex_whilo;
          mem_hi       <= ex_hi;
          mem_lo       <= ex_lo;
          mem_aluop    <= ex_aluop;
          mem_mem_addr <= ex_mem_addr;
          mem_reg2     <= ex_reg2;
          hilo_o       <= '0;
          cnt_o        <= '0;
        end
        default: ; // hold
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: scoreboard bench for the EX/MEM pipeline register.
// Stimulus is directed first, then randomized.
module tb_ex_mem;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  rec_t        in;
  rec_t        out;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  rec_t        model;
  rec_t        exp_q[$];

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(in.wd), .ex_wreg(in.wreg), .ex_wdata(in.wdata),
    .ex_whilo(in.whilo), .ex_hi(in.hi), .ex_lo(in.lo),
    .ex_aluop(in.aluop), .ex_mem_addr(in.mem_addr), .ex_reg2(in.reg2),
    .hilo_i(in.hilo), .cnt_i(in.cnt),
    .mem_wd(out.wd), .mem_wreg(out.wreg), .mem_wdata(out.wdata),
    .mem_whilo(out.whilo), .mem_hi(out.hi), .mem_lo(out.lo),
    .mem_aluop(out.aluop), .mem_mem_addr(out.mem_addr), .mem_reg2(out.reg2),
    .hilo_o(out.hilo), .cnt_o(out.cnt)
  );

  // Reference: what the register holds after one edge.
  function automatic rec_t predict(rec_t cur, rec_t x, logic r, logic f, logic [5:0] s);
    rec_t n;
    if (r || f) return '0;
    if (!s[3]) begin                 // EX moves on: MEM gets EX, loop-back cleared
      n = x;
      n.hilo = '0;
      n.cnt  = '0;
      return n;
    end
    if (!s[4]) begin                 // EX stuck, MEM free: empty slot, loop-back kept
      n = '0;
      n.hilo = x.hilo;
      n.cnt  = x.cnt;
      return n;
    end
    return cur;                      // both stuck
  endfunction

  task automatic check(string name, rec_t act, rec_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h aluop=%h addr=%h reg2=%h hilo=%h cnt=%h",
               name, act.wd, act.wreg, act.wdata, act.whilo, act.hi, act.lo,
               act.aluop, act.mem_addr, act.reg2, act.hilo, act.cnt);
      $display("     %s: want wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h aluop=%h addr=%h reg2=%h hilo=%h cnt=%h",
               name, exp.wd, exp.wreg, exp.wdata, exp.whilo, exp.hi, exp.lo,
               exp.aluop, exp.mem_addr, exp.reg2, exp.hilo, exp.cnt);
    end
  endtask

  // Monitor: after each edge, pop the expected register contents and compare.
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("edge", out, e);
      end
    end
  end

  // Apply the current inputs for one edge, pushing the expected result.
  task automatic cycle();
    model = predict(model, in, rst, flush, stall);
    exp_q.push_back(model);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_in();
    in.wd       = 5'($urandom);
    in.wreg     = 1'($urandom);
    in.wdata    = $urandom;
    in.whilo    = 1'($urandom);
    in.hi       = $urandom;
    in.lo       = $urandom;
    in.aluop    = 8'($urandom);
    in.mem_addr = $urandom;
    in.reg2     = $urandom;
    in.hilo     = {$urandom, $urandom};
    in.cnt      = 2'($urandom);
  endtask

  initial begin
    rec_t r;
    rst = 1'b1; flush = 1'b0; stall = '0; in = '0; model = '0;
    rand_in();
    #2;
    check("reset_async", out, '0);
    cycle();                                  // reset held across an edge
    rst = 1'b0;

    // Advance
    rand_in(); in.wd = 5'd3; in.wreg = 1'b1; in.wdata = 32'h1234_5678;
    cycle();
    // Bubble with a multi-cycle op in flight, then advance
    stall = 6'b001111; in.hilo = 64'hA; in.cnt = 2'b01; in.wreg = 1'b1;
    cycle();
    stall = '0; rand_in(); in.wdata = 32'h55;
    cycle();
    // Hold for three edges
    in.wdata = 32'hDEAD_BEEF;
    cycle();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      cycle();
    end
    // Flush beats stall
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    // Asynchronous reset between edges
    stall = '0; rand_in(); in.wdata = 32'hFFFF_FFFF;
    cycle();
    #2 rst = 1'b1;
    #1;
    check("reset_midcycle", out, '0);
    model = '0;
    @(negedge clk);
    rst = 1'b0; stall = '0; in.wdata = 32'h7;
    cycle();
    // Reset during hold discards held state
    stall = 6'b011111; rand_in();
    cycle();
    rst = 1'b1; #1;
    check("reset_in_hold", out, '0);
    model = '0;
    cycle();
    rst = 1'b0;
    cycle();
    // Illegal stall combination behaves as advance
    stall = 6'b010000; rand_in(); in.wdata = 32'h9;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_in();
      case ($urandom_range(0, 5))
        0, 1: stall = 6'b000000;
        2:    stall = 6'b001111;
        3:    stall = 6'b011111;
        4:    stall = 6'b010000;
        default: stall = 6'($urandom);
      endcase
      flush = ($urandom_range(0, 9) == 0);
      cycle();
    end
    flush = 1'b0;
    @(posedge clk); #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected results left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
